// File: rtl/encoder_4x2_handshake_pkg.sv
// Shared definitions for the 4-to-2 handshake encoder: state encoding, default debounce length, encode helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package encoder_4x2_handshake_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam int DEB_CYCLES_DEFAULT = 4;

  // Highest set line wins; an all-zero snapshot never reaches capture, so 0 is a safe fallback.
  function automatic logic [1:0] prio_enc(input logic [3:0] s);
    logic [1:0] r;
    if (s[3])      r = 2'd3;
    else if (s[2]) r = 2'd2;
    else if (s[1]) r = 2'd1;
    else           r = 2'd0;
    return r;
  endfunction

  // True when more than one request line is set.
  function automatic logic multi_hot(input logic [3:0] s);
    logic [2:0] pc;
    pc = {2'b00, s[0]} + {2'b00, s[1]} + {2'b00, s[2]} + {2'b00, s[3]};
    return (pc > 3'd1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, cleared by reset.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; free-running sampler.
// Ports: clk (clock), nrst (async active-low clear), d (async input), q (synchronised output).
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/encoder_4x2_handshake.sv
// Debounced 4-to-2 priority encoder presenting one code per press under a valid/ack handshake.
// Latency: V rises on edge 3+DEB_CYCLES after D settles (2 sync + 1 arm + DEB_CYCLES debounce).
// Backpressure: code held in HOLD until ack; re-arms only after all lines are released.
// Ports: clk, nrst (async active-low), D[3:0] async requests (D[3] highest), E enable,
//        ack consumer acknowledge, A[1:0] code, V code valid, M multiple lines at capture.
module encoder_4x2_handshake
  import encoder_4x2_handshake_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int CNT_W      = 3
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] D,
  input  logic       E,
  input  logic       ack,
  output logic [1:0] A,
  output logic       V,
  output logic       M
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       ds;
  logic [3:0]       snap;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       a_q;
  logic             v_q;
  logic             m_q;

  // control strobes derived from the current/next state pair
  logic             arm;
  logic             count;
  logic             capture;
  logic             take;

  sync_2ff #(.W(4)) u_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (D),
    .q    (ds)
  );

  // state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (E && (ds != 4'b0000)) state_nxt = DEBOUNCE;
      end
      DEBOUNCE: begin
        // any change of the pattern, or losing enable, restarts from scratch
        if (!E || (ds != snap))  state_nxt = IDLE;
        else if (cnt == CNT_LAST) state_nxt = HOLD;
      end
      HOLD: begin
        // enable is deliberately ignored here: the code is already committed
        if (ack) state_nxt = RELEASE;
      end
      RELEASE: begin
        if (ds == 4'b0000) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // output/control decode
  always_comb begin
    arm     = (state == IDLE)     && (state_nxt == DEBOUNCE);
    count   = (state == DEBOUNCE) && (state_nxt == DEBOUNCE);
    capture = (state == DEBOUNCE) && (state_nxt == HOLD);
    take    = (state == HOLD)     && ack;
  end

  // datapath: snapshot, debounce counter and registered outputs.
  // The counter stops at CNT_LAST because DEBOUNCE is left on that value, so it never wraps.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      snap <= 4'b0000;
      cnt  <= '0;
      a_q  <= 2'd0;
      m_q  <= 1'b0;
      v_q  <= 1'b0;
    end else begin
      if (arm) begin
        snap <= ds;
        cnt  <= '0;
      end
      if (count) cnt <= cnt + CNT_W'(1);
      if (capture) begin
        a_q <= prio_enc(snap);
        m_q <= multi_hot(snap);
        v_q <= 1'b1;
      end
      // A and M deliberately keep their value after V falls
      if (take) v_q <= 1'b0;
    end
  end

  assign A = a_q;
  assign V = v_q;
  assign M = m_q;

endmodule

// File: tb/tb_encoder_4x2_handshake.sv
// Self-checking bench for encoder_4x2_handshake: vector table plus hand sequences, scoreboard on V rise.
// Latency: n/a.
// Backpressure: n/a.
module tb_encoder_4x2_handshake;

  logic       clk = 1'b0;
  logic       nrst;
  logic [3:0] D;
  logic       E;
  logic       ack;
  logic [1:0] A;
  logic       V;
  logic       M;

  logic [3:0] D2;
  logic       E2;
  logic       ack2;
  logic [1:0] A2;
  logic       V2;
  logic       M2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] a;
    logic       m;
  } exp_t;

  typedef struct {
    logic [3:0] d;
    logic [1:0] a;
    logic       m;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  logic v_prev = 1'b0;

  always #5 clk = ~clk;

  encoder_4x2_handshake dut (
    .clk  (clk),
    .nrst (nrst),
    .D    (D),
    .E    (E),
    .ack  (ack),
    .A    (A),
    .V    (V),
    .M    (M)
  );

  encoder_4x2_handshake #(.DEB_CYCLES(1), .CNT_W(1)) dut_fast (
    .clk  (clk),
    .nrst (nrst),
    .D    (D2),
    .E    (E2),
    .ack  (ack2),
    .A    (A2),
    .V    (V2),
    .M    (M2)
  );

  // reference 2x4 decoder
  function automatic logic [3:0] dec2x4(input logic [1:0] a, input logic en);
    logic [3:0] r;
    r = en ? (4'b0001 << a) : 4'b0000;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // counts edges until V is seen, bounded
  task automatic wait_v(input string name, input int exp_edges);
    int n;
    n = 0;
    while (V !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    chk(name, n, exp_edges);
  endtask

  task automatic wait_v2(input string name, input int exp_edges);
    int n;
    n = 0;
    while (V2 !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    chk(name, n, exp_edges);
  endtask

  // scoreboard: every V rise must match the oldest expected code
  always @(posedge clk) begin
    #1;
    if (V === 1'b1 && v_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_v", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_a", A, e.a);
        chk("sb_m", M, e.m);
      end
    end
    v_prev = V;
  end

  initial begin
    logic       seen_v;
    logic [3:0] d;

    nrst = 1'b0; D = 4'b0000; E = 1'b0; ack = 1'b0;
    D2 = 4'b0000; E2 = 1'b0; ack2 = 1'b0;

    vecs[0] = '{4'b0010, 2'd1, 1'b0};
    vecs[1] = '{4'b1011, 2'd3, 1'b1};
    vecs[2] = '{4'b0001, 2'd0, 1'b0};
    vecs[3] = '{4'b0100, 2'd2, 1'b0};
    vecs[4] = '{4'b1000, 2'd3, 1'b0};
    vecs[5] = '{4'b0110, 2'd2, 1'b1};
    vecs[6] = '{4'b1111, 2'd3, 1'b1};

    #12;
    chk("reset_a", A, 0);
    chk("reset_v", V, 0);
    chk("reset_m", M, 0);
    @(negedge clk);
    nrst = 1'b1;
    step(2);

    // reset asserted in the middle of DEBOUNCE
    E = 1'b1;
    D = 4'b0100;
    sb.push_back('{2'd2, 1'b0});
    step(4);
    chk("debounce_v_low", V, 0);
    nrst = 1'b0;
    #2;
    chk("rst_dbn_v", V, 0);
    chk("rst_dbn_a", A, 0);
    chk("rst_dbn_m", M, 0);
    #2;
    nrst = 1'b1;
    wait_v("lat_after_reset", 7);
    chk("after_reset_a", A, 2);
    ack = 1'b1;
    step(1);
    chk("after_reset_ack_v", V, 0);
    ack = 1'b0;
    D = 4'b0000;
    step(4);

    // table of single presses
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{vecs[i].a, vecs[i].m});
      D = vecs[i].d;
      wait_v($sformatf("lat_vec%0d", i), 7);
      chk($sformatf("a_vec%0d", i), A, vecs[i].a);
      chk($sformatf("m_vec%0d", i), M, vecs[i].m);
      step(3);
      chk($sformatf("hold_v_vec%0d", i), V, 1);
      chk($sformatf("hold_a_vec%0d", i), A, vecs[i].a);
      ack = 1'b1;
      step(1);
      chk($sformatf("ack_v_vec%0d", i), V, 0);
      chk($sformatf("keep_a_vec%0d", i), A, vecs[i].a);
      chk($sformatf("keep_m_vec%0d", i), M, vecs[i].m);
      ack = 1'b0;
      seen_v = 1'b0;
      for (int k = 0; k < 12; k++) begin
        step(1);
        seen_v |= V;
      end
      chk($sformatf("no_rearm_vec%0d", i), seen_v, 0);
      D = 4'b0000;
      step(4);
    end

    // reset while a code is held
    sb.push_back('{2'd3, 1'b1});
    D = 4'b1101;
    wait_v("lat_hold_rst", 7);
    D = 4'b0000;
    nrst = 1'b0;
    #2;
    chk("rst_hold_v", V, 0);
    chk("rst_hold_a", A, 0);
    chk("rst_hold_m", M, 0);
    #2;
    nrst = 1'b1;
    step(4);

    // bouncing key: 2 cycles on, 2 cycles off
    seen_v = 1'b0;
    for (int i = 0; i < 20; i++) begin
      D = (((i / 2) % 2) == 0) ? 4'b0100 : 4'b0000;
      step(1);
      seen_v |= V;
    end
    chk("bounce_v", seen_v, 0);
    D = 4'b0000;
    step(4);
    sb.push_back('{2'd2, 1'b0});
    D = 4'b0100;
    wait_v("lat_after_bounce", 7);
    chk("bounce_a", A, 2);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    D = 4'b0000;
    step(4);

    // enable low: no capture
    E = 1'b0;
    D = 4'b1000;
    seen_v = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      seen_v |= V;
    end
    chk("enable_low_v", seen_v, 0);
    D = 4'b0000;
    step(4);

    // enable drops during DEBOUNCE
    E = 1'b1;
    D = 4'b1000;
    step(5);
    E = 1'b0;
    seen_v = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      seen_v |= V;
    end
    chk("enable_drop_dbn_v", seen_v, 0);
    D = 4'b0000;
    E = 1'b1;
    step(6);

    // enable drops in HOLD: code stays valid
    sb.push_back('{2'd3, 1'b0});
    D = 4'b1000;
    wait_v("lat_en_hold", 7);
    E = 1'b0;
    step(3);
    chk("enable_drop_hold_v", V, 1);
    ack = 1'b1;
    step(1);
    chk("enable_drop_ack_v", V, 0);
    ack = 1'b0;
    E = 1'b1;
    D = 4'b0000;
    step(4);

    // ack held high: one HOLD cycle per transfer
    ack = 1'b1;
    sb.push_back('{2'd1, 1'b0});
    D = 4'b0010;
    wait_v("lat_ack_high", 7);
    step(1);
    chk("ack_high_one_cycle", V, 0);
    D = 4'b0000;
    step(4);
    ack = 1'b0;

    // round trip through the 2x4 decoder on the DEB_CYCLES=1 instance
    for (int i = 0; i < 4; i++) begin
      d = 4'b0001 << i;
      E2 = 1'b1;
      D2 = d;
      wait_v2($sformatf("lat_fast%0d", i), 4);
      chk($sformatf("roundtrip%0d", i), dec2x4(A2, 1'b1), d);
      chk($sformatf("fast_m%0d", i), M2, 0);
      ack2 = 1'b1;
      step(1);
      ack2 = 1'b0;
      D2 = 4'b0000;
      step(4);
    end

    step(3);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
